// File: rtl/spi_cmd_ram_param.sv
// Command-decoded single-port RAM behind the SPI slave: separate write/read
// address registers, optional burst auto-increment, 1- or 2-cycle read latency.
module spi_cmd_ram_param #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned AUTO_INC     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [WIDTH+1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             tx_valid,
  output logic             err
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [WIDTH:0]   DEPTH_EXT = (WIDTH+1)'(MEM_DEPTH);
  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  logic [WIDTH-1:0] mem [MEM_DEPTH];

  logic [WIDTH-1:0] wr_addr, wr_addr_d;
  logic [WIDTH-1:0] rd_addr, rd_addr_d;

  cmd_e             cmd_c;
  logic [WIDTH-1:0] payload_c;
  logic             wr_fire_c;
  logic             rd_fire_c;
  logic             wr_in_range_c;
  logic             rd_in_range_c;
  logic             wr_en_c;
  logic [AW-1:0]    wr_idx_c;
  logic [AW-1:0]    rd_idx_c;
  logic [WIDTH-1:0] rd_word_c;
  logic             err_d;

  // Burst advance: last legal word wraps to zero.
  function automatic logic [WIDTH-1:0] next_addr(input logic [WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + WIDTH'(1);
  endfunction

  // Command decode and range checks on the full address width.
  always_comb begin
    cmd_c         = cmd_e'(din[WIDTH+1:WIDTH]);
    payload_c     = din[WIDTH-1:0];
    wr_fire_c     = rx_valid && (cmd_c == CMD_WR_DATA);
    rd_fire_c     = rx_valid && (cmd_c == CMD_RD_DATA);
    wr_in_range_c = {1'b0, wr_addr} < DEPTH_EXT;
    rd_in_range_c = {1'b0, rd_addr} < DEPTH_EXT;
    wr_en_c       = wr_fire_c && wr_in_range_c;
    wr_idx_c      = wr_addr[AW-1:0];
    rd_idx_c      = rd_addr[AW-1:0];
    rd_word_c     = rd_in_range_c ? mem[rd_idx_c] : '0;
    err_d         = (wr_fire_c && !wr_in_range_c) || (rd_fire_c && !rd_in_range_c);
  end

  // Address register next-state; out-of-range addresses never advance.
  always_comb begin
    wr_addr_d = wr_addr;
    rd_addr_d = rd_addr;
    if (rx_valid) begin
      case (cmd_c)
        CMD_WR_ADDR: wr_addr_d = payload_c;
        CMD_WR_DATA: if ((AUTO_INC != 0) && wr_in_range_c) wr_addr_d = next_addr(wr_addr);
        CMD_RD_ADDR: rd_addr_d = payload_c;
        CMD_RD_DATA: if ((AUTO_INC != 0) && rd_in_range_c) rd_addr_d = next_addr(rd_addr);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      err     <= 1'b0;
    end else begin
      wr_addr <= wr_addr_d;
      rd_addr <= rd_addr_d;
      err     <= err_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_idx_c] <= payload_c;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             s1_vld;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld   <= 1'b0;
        s1_data  <= '0;
        tx_valid <= 1'b0;
        dout     <= '0;
      end else begin
        s1_vld   <= rd_fire_c;
        if (rd_fire_c) s1_data <= rd_word_c;
        tx_valid <= s1_vld;
        if (s1_vld) dout <= s1_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tx_valid <= 1'b0;
        dout     <= '0;
      end else begin
        tx_valid <= rd_fire_c;
        if (rd_fire_c) dout <= rd_word_c;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ram_param.sv
// Scoreboard bench: instance a uses defaults, instance b is a 16-word,
// 2-cycle-latency, auto-increment build.
module tb_spi_cmd_ram_param;

  localparam logic [1:0] C_WA = 2'b00;
  localparam logic [1:0] C_WD = 2'b01;
  localparam logic [1:0] C_RA = 2'b10;
  localparam logic [1:0] C_RD = 2'b11;

  typedef struct {
    int unsigned due;
    logic [7:0]  data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid_a, rx_valid_b;
  logic [9:0] din_a, din_b;
  logic [7:0] dout_a, dout_b;
  logic       tx_valid_a, tx_valid_b;
  logic       err_a, err_b;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        txq_a[$];
  exp_t        txq_b[$];
  int unsigned errq_b[$];
  logic [7:0]  last_a = 8'h00;
  logic [7:0]  last_b = 8'h00;

  spi_cmd_ram_param u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid_a),
    .din      (din_a),
    .dout     (dout_a),
    .tx_valid (tx_valid_a),
    .err      (err_a)
  );

  spi_cmd_ram_param #(
    .WIDTH        (8),
    .MEM_DEPTH    (16),
    .READ_LATENCY (2),
    .AUTO_INC     (1)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid_b),
    .din      (din_b),
    .dout     (dout_b),
    .tx_valid (tx_valid_b),
    .err      (err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int unsigned got, input int unsigned want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h cyc=%0d", nm, got, want, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations as outputs appear.
  always @(negedge clk) begin
    exp_t        e;
    int unsigned d;
    if (!rst_n) begin
      check("a_rst_tx_valid", 32'(tx_valid_a), 0);
      check("a_rst_dout", 32'(dout_a), 0);
      check("a_rst_err", 32'(err_a), 0);
      check("b_rst_tx_valid", 32'(tx_valid_b), 0);
      check("b_rst_dout", 32'(dout_b), 0);
      check("b_rst_err", 32'(err_b), 0);
      last_a = 8'h00;
      last_b = 8'h00;
    end else begin
      if (tx_valid_a) begin
        if (txq_a.size() == 0) check("a_tx_unexpected", 32'(tx_valid_a), 0);
        else begin
          e = txq_a.pop_front();
          check("a_tx_cycle", cyc, e.due);
          check("a_dout", 32'(dout_a), 32'(e.data));
          last_a = e.data;
        end
      end else begin
        if (txq_a.size() != 0 && txq_a[0].due <= cyc) begin
          e = txq_a.pop_front();
          check("a_tx_missing", 32'(tx_valid_a), 1);
        end
        check("a_dout_hold", 32'(dout_a), 32'(last_a));
      end
      check("a_err", 32'(err_a), 0);

      if (tx_valid_b) begin
        if (txq_b.size() == 0) check("b_tx_unexpected", 32'(tx_valid_b), 0);
        else begin
          e = txq_b.pop_front();
          check("b_tx_cycle", cyc, e.due);
          check("b_dout", 32'(dout_b), 32'(e.data));
          last_b = e.data;
        end
      end else begin
        if (txq_b.size() != 0 && txq_b[0].due <= cyc) begin
          e = txq_b.pop_front();
          check("b_tx_missing", 32'(tx_valid_b), 1);
        end
        check("b_dout_hold", 32'(dout_b), 32'(last_b));
      end

      if (err_b) begin
        if (errq_b.size() == 0) check("b_err_unexpected", 32'(err_b), 0);
        else begin
          d = errq_b.pop_front();
          check("b_err_cycle", cyc, d);
        end
      end else if (errq_b.size() != 0 && errq_b[0] <= cyc) begin
        d = errq_b.pop_front();
        check("b_err_missing", 32'(err_b), 1);
      end
    end
  end

  task automatic set_in(input logic va, input logic [1:0] ca, input logic [7:0] pa,
                        input logic vb, input logic [1:0] cb, input logic [7:0] pb);
    rx_valid_a = va;
    din_a      = {ca, pa};
    rx_valid_b = vb;
    din_b      = {cb, pb};
  endtask

  task automatic drive(input logic va, input logic [1:0] ca, input logic [7:0] pa,
                       input logic vb, input logic [1:0] cb, input logic [7:0] pb);
    @(negedge clk);
    set_in(va, ca, pa, vb, cb, pb);
  endtask

  task automatic a_cmd(input logic [1:0] c, input logic [7:0] p);
    drive(1'b1, c, p, 1'b0, C_WA, 8'h00);
  endtask

  task automatic b_cmd(input logic [1:0] c, input logic [7:0] p);
    drive(1'b0, C_WA, 8'h00, 1'b1, c, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, C_WA, 8'h00, 1'b0, C_WA, 8'h00);
  endtask

  task automatic exp_a(input logic [7:0] d);
    txq_a.push_back('{due: cyc + 1, data: d});
  endtask

  task automatic exp_b(input logic [7:0] d);
    txq_b.push_back('{due: cyc + 2, data: d});
  endtask

  task automatic exp_b_err();
    errq_b.push_back(cyc + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, C_WA, 8'h00, 1'b0, C_WA, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read on the default build.
    a_cmd(C_WA, 8'h2A);
    a_cmd(C_WD, 8'h5C);
    a_cmd(C_RA, 8'h2A);
    a_cmd(C_RD, 8'h00); exp_a(8'h5C);
    idle(2);
    // Read immediately after write to the same address.
    a_cmd(C_WA, 8'h07);
    a_cmd(C_RA, 8'h07);
    a_cmd(C_WD, 8'h99);
    a_cmd(C_RD, 8'h00); exp_a(8'h99);
    a_cmd(C_WA, 8'h00);
    a_cmd(C_WD, 8'h3C);
    idle(2);

    // Latency 2 with auto-increment, back-to-back reads.
    b_cmd(C_WA, 8'h00);
    b_cmd(C_WD, 8'h11);
    b_cmd(C_WD, 8'h22);
    b_cmd(C_WD, 8'h33);
    b_cmd(C_RA, 8'h00);
    b_cmd(C_RD, 8'h00); exp_b(8'h11);
    b_cmd(C_RD, 8'h00); exp_b(8'h22);
    b_cmd(C_RD, 8'h00); exp_b(8'h33);
    idle(3);

    // Burst wrap at the top of a 16-word memory.
    b_cmd(C_WA, 8'd14);
    b_cmd(C_WD, 8'hA0);
    b_cmd(C_WD, 8'hA1);
    b_cmd(C_WD, 8'hA2);
    b_cmd(C_RA, 8'd14);
    b_cmd(C_RD, 8'h00); exp_b(8'hA0);
    b_cmd(C_RD, 8'h00); exp_b(8'hA1);
    b_cmd(C_RD, 8'h00); exp_b(8'hA2);
    idle(3);

    // Out of range: exactly MEM_DEPTH and beyond; aliases of word 0 and 4 must survive.
    b_cmd(C_WA, 8'd4);
    b_cmd(C_WD, 8'h44);
    b_cmd(C_WA, 8'd16);
    b_cmd(C_WD, 8'h55); exp_b_err();
    b_cmd(C_WA, 8'd20);
    b_cmd(C_WD, 8'hFF); exp_b_err();
    b_cmd(C_RA, 8'd20);
    b_cmd(C_RD, 8'h00); exp_b_err(); exp_b(8'h00);
    idle(2);
    b_cmd(C_RA, 8'd4);
    b_cmd(C_RD, 8'h00); exp_b(8'h44);
    b_cmd(C_RA, 8'd0);
    b_cmd(C_RD, 8'h00); exp_b(8'hA2);
    idle(3);

    // Invalid beats carrying read-data commands must do nothing.
    for (int i = 0; i < 10; i++) drive(1'b0, C_RD, 8'h05, 1'b0, C_RD, 8'h05);
    a_cmd(C_WD, 8'h3D);
    a_cmd(C_RD, 8'h00); exp_a(8'h99);
    b_cmd(C_RD, 8'h00); exp_b(8'h22);
    idle(3);

    // Reset one cycle after a read is accepted on the latency-2 build.
    b_cmd(C_RD, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, C_RD, 8'h00, 1'b1, C_RD, 8'h00);
    exp_a(8'h3D);
    exp_b(8'hA2);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ram_param.md
# spi_cmd_ram_param

Parametrised single-port RAM behind the SPI slave's command channel. It replaces the fixed 8-bit/256-word command RAM. Each beat from the SPI slave carries a 2-bit command plus a payload; the block decodes the command, holds separate write and read address registers, and returns read data to the SPI slave with a `tx_valid` strobe. New over the fixed version:

- configurable data/address width, depth and read latency;
- optional address auto-increment for burst access;
- an out-of-range error strobe.

## Interface

Parameters:
- `WIDTH`, 8: payload width. Used as both address width and data width.
- `MEM_DEPTH`, 256: number of words. Legal range is 2 to 2**WIDTH.
- `READ_LATENCY`, 1: cycles from read-data command to `tx_valid`. Legal values are 1 or 2.
- `AUTO_INC`, 0: when 1, the relevant address register post-increments after every data access.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  `din` is valid this cycle.
- `din`  in  WIDTH+2  [WIDTH+1:WIDTH] = command, [WIDTH-1:0] = payload.
- `dout`  out  WIDTH  read data; holds its value between reads.
- `tx_valid`  out  1  one-cycle strobe, `dout` is valid.
- `err`  out  1  one-cycle strobe, out-of-range access.

## Operation

- Reset (async assert, sync-safe release) sets `dout`=0, `tx_valid`=0, `err`=0, `wr_addr`=0, `rd_addr`=0. The read pipeline is flushed. Memory contents are not reset.
- The command applies only when `rx_valid`=1. With `rx_valid`=0, no state other than the read pipeline changes.
- 2'b00, write address: `wr_addr` <= payload.
- 2'b01, write data: if `wr_addr` < MEM_DEPTH, `mem[wr_addr]` <= payload; otherwise the write is dropped and `err` pulses. If AUTO_INC=1, `wr_addr` then advances: MEM_DEPTH-1 wraps to 0; an out-of-range value is left unchanged.
- 2'b10, read address: `rd_addr` <= payload.
- 2'b11, read data: issues a read of `mem[rd_addr]`. An out-of-range read returns 0 and pulses `err`. If AUTO_INC=1, `rd_addr` advances with the same wrap rule as `wr_addr`. The payload is ignored.
- One command per cycle. Read-after-write to the same address in consecutive cycles returns the newly written value.
- Address and data payloads share the `din` field. Out-of-range detection compares the full WIDTH-bit address against MEM_DEPTH.

## Timing

- READ_LATENCY=1: `rx_valid`&&cmd==11 in cycle N gives `tx_valid`=1 with `dout` valid in cycle N+1.
- READ_LATENCY=2: the same condition gives `tx_valid` in cycle N+2 (registered memory output plus output register).
- `tx_valid` is never high unless a read-data command was accepted exactly READ_LATENCY cycles earlier. In all other cases it is 0.
- Back-to-back read-data commands produce back-to-back `tx_valid` pulses with no bubbles. The pipeline is fully pipelined, with no backpressure.
- `dout` updates only in cycles where `tx_valid`=1.
- `err` asserts in cycle N+1 for an offending command in cycle N, for both reads and writes, independent of READ_LATENCY.
- Reset asserted mid-read discards the in-flight read: no `tx_valid` after release.
- Commands in the first cycle after `rst_n` release are accepted normally.

## Test plan

- Reset check (defaults): assert `rst_n`=0 mid-burst. Required: `tx_valid`=0, `dout`=0, `err`=0 immediately. A read command issued 1 cycle before reset produces no strobe.
- Basic R/W (defaults): cmd00 payload 0x2A; cmd01 payload 0x5C; cmd10 payload 0x2A; cmd11. Required: `tx_valid`=1 and `dout`=0x5C exactly one cycle after cmd11. `tx_valid` is 0 in all other cycles.
- Latency (READ_LATENCY=2): three back-to-back cmd11 after preloading addresses 0..2 with 0x11/0x22/0x33, with AUTO_INC=1. Required: `tx_valid` high in cycles N+2..N+4 with `dout` 0x11, 0x22, 0x33.
- Burst wrap (AUTO_INC=1, MEM_DEPTH=16, WIDTH=8): cmd00 payload 14, then cmd01 0xA0, 0xA1, 0xA2. Required: `mem[14]`=0xA0, `mem[15]`=0xA1, `mem[0]`=0xA2, and `err` never asserts.
- Out of range (MEM_DEPTH=16): cmd00 payload 20; cmd01 payload 0xFF. Then cmd10 payload 20; cmd11. Required: `err` pulses one cycle after each data command, no memory word changes, and the read returns `dout`=0 with `tx_valid`=1.
- Idle/invalid: `rx_valid`=0 with `din`[9:8]=11 for 10 cycles. Required: `tx_valid`=0, `err`=0, and address registers unchanged throughout.
